// File: rtl/cdp1802_pkg.sv
// Shared state-code constants, default timing parameters and machine-state type
// for the CDP1802 DMA/interrupt responder.
package cdp1802_pkg;

  localparam logic [1:0] SC_FETCH = 2'd0;
  localparam logic [1:0] SC_EXEC  = 2'd1;
  localparam logic [1:0] SC_DMA   = 2'd2;
  localparam logic [1:0] SC_INT   = 2'd3;

  localparam int DEF_CLKS_PER_CYCLE = 8;
  localparam int DEF_TPA_PHASE      = 1;
  localparam int DEF_TPB_PHASE      = 6;
  localparam int DEF_ADDR_W         = 16;

  typedef enum logic [1:0] {
    ST_FETCH = SC_FETCH,
    ST_EXEC  = SC_EXEC,
    ST_DMA   = SC_DMA,
    ST_INT   = SC_INT
  } mstate_e;

endpackage

// File: rtl/cdp1802_cycle_timer.sv
// Machine-cycle phase counter with registered TPA/TPB pulses and an
// end-of-cycle strobe that is high during the last phase.
module cdp1802_cycle_timer
  import cdp1802_pkg::*;
#(
  parameter int CLKS_PER_CYCLE = DEF_CLKS_PER_CYCLE,
  parameter int TPA_PHASE      = DEF_TPA_PHASE,
  parameter int TPB_PHASE      = DEF_TPB_PHASE,
  parameter int PHASE_W        = $clog2(DEF_CLKS_PER_CYCLE)
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  output logic [PHASE_W-1:0] phase_o,
  output logic [PHASE_W-1:0] phase_next_o,
  output logic               tpa_o,
  output logic               tpb_o,
  output logic               cycle_end_o
);

  localparam logic [PHASE_W-1:0] LAST_P = PHASE_W'(CLKS_PER_CYCLE - 1);
  localparam logic [PHASE_W-1:0] TPA_P  = PHASE_W'(TPA_PHASE);
  localparam logic [PHASE_W-1:0] TPB_P  = PHASE_W'(TPB_PHASE);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               tpa_q, tpb_q;

  assign phase_d = (phase_q == LAST_P) ? '0 : phase_q + PHASE_W'(1);

  // Pulses are decoded from the next phase so they line up exactly with it.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      phase_q <= '0;
      tpa_q   <= 1'b0;
      tpb_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      tpa_q   <= (phase_d == TPA_P);
      tpb_q   <= (phase_d == TPB_P);
    end
  end

  assign phase_o      = phase_q;
  assign phase_next_o = phase_d;
  assign tpa_o        = tpa_q;
  assign tpb_o        = tpb_q;
  assign cycle_end_o  = (phase_q == LAST_P);

endmodule

// File: rtl/cdp1802_dma_responder.sv
// CPU-side machine-cycle sequencer answering CDP1861 DMA-out and interrupt requests.
// Define CDP1802_DMA_IN_EN to add DMA-in (DMAI, dma_in_data, ram_wr, ram_d).
module cdp1802_dma_responder
  import cdp1802_pkg::*;
#(
  parameter int CLKS_PER_CYCLE = DEF_CLKS_PER_CYCLE,
  parameter int TPA_PHASE      = DEF_TPA_PHASE,
  parameter int TPB_PHASE      = DEF_TPB_PHASE,
  parameter int ADDR_W         = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              DMAO,
  input  logic              INT,
  input  logic              ie_set,
  input  logic              ie_clr,
  input  logic              r0_load,
  input  logic [ADDR_W-1:0] r0_in,
  output logic [ADDR_W-1:0] r0_out,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_a,
  input  logic [7:0]        ram_q,
  output logic [7:0]        dma_data,
  output logic              TPA,
  output logic              TPB,
  output logic [1:0]        SC,
  output logic              ie,
  output logic              int_ack,
  output logic              core_stall
`ifdef CDP1802_DMA_IN_EN
  ,
  input  logic              DMAI,
  input  logic [7:0]        dma_in_data,
  output logic              ram_wr,
  output logic [7:0]        ram_d
`endif
);

  localparam int PHASE_W = $clog2(CLKS_PER_CYCLE);
  localparam logic [PHASE_W-1:0] TPB_P      = PHASE_W'(TPB_PHASE);
  localparam logic [PHASE_W-1:0] XFER_FIRST = PHASE_W'(2);
  localparam logic [PHASE_W-1:0] XFER_LAST  = PHASE_W'(TPB_PHASE - 1);

  logic [PHASE_W-1:0] phase, phaseNext;
  logic               cycleEnd;
  logic               stalled;
  logic               dmaInSeen, dmaInCycle;

  mstate_e            state_q, state_d;
  logic [ADDR_W-1:0]  r0_q, r0_d;
  logic               ie_q, ie_d;
  logic               dmaReq_q, dmaReq_d;
  logic               intReq_q, intReq_d;
  logic               ramRd_q, ramRd_d;
  logic [7:0]         dmaData_q, dmaData_d;
  logic               intAck_q, intAck_d;

  cdp1802_cycle_timer #(
    .CLKS_PER_CYCLE(CLKS_PER_CYCLE),
    .TPA_PHASE     (TPA_PHASE),
    .TPB_PHASE     (TPB_PHASE),
    .PHASE_W       (PHASE_W)
  ) u_timer (
    .clock_i     (clock),
    .reset_ni    (reset),
    .phase_o     (phase),
    .phase_next_o(phaseNext),
    .tpa_o       (TPA),
    .tpb_o       (TPB),
    .cycle_end_o (cycleEnd)
  );

  assign stalled = (state_q == ST_DMA) || (state_q == ST_INT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_EXEC;
      r0_q      <= '0;
      ie_q      <= 1'b1;
      dmaReq_q  <= 1'b0;
      intReq_q  <= 1'b0;
      ramRd_q   <= 1'b0;
      dmaData_q <= 8'h00;
      intAck_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      r0_q      <= r0_d;
      ie_q      <= ie_d;
      dmaReq_q  <= dmaReq_d;
      intReq_q  <= intReq_d;
      ramRd_q   <= ramRd_d;
      dmaData_q <= dmaData_d;
      intAck_q  <= intAck_d;
    end
  end

  // Requests are sampled once per cycle at TPB and acted on at the cycle boundary.
  always_comb begin
    state_d   = state_q;
    r0_d      = r0_q;
    ie_d      = ie_q;
    dmaReq_d  = dmaReq_q;
    intReq_d  = intReq_q;
    dmaData_d = dmaData_q;
    if (phase == TPB_P) begin
      dmaReq_d = ~DMAO;
      intReq_d = ~INT & ie_q;
    end
    if (cycleEnd) begin
      case (state_q)
        ST_FETCH: state_d = ST_EXEC;
        ST_EXEC, ST_DMA: begin
          if (dmaInSeen || dmaReq_q) state_d = ST_DMA;
          else if (intReq_q)         state_d = ST_INT;
          else                       state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
    if ((state_q == ST_DMA) && cycleEnd) r0_d = r0_q + ADDR_W'(1);
    else if (r0_load && !stalled)        r0_d = r0_in;
    ramRd_d = (state_q == ST_DMA) && !dmaInCycle &&
              (phaseNext >= XFER_FIRST) && (phaseNext <= XFER_LAST);
    if ((state_q == ST_DMA) && !dmaInCycle && (phase == XFER_LAST)) dmaData_d = ram_q;
    intAck_d = cycleEnd && (state_d == ST_INT);
    if (intAck_d)    ie_d = 1'b0;
    else if (ie_clr) ie_d = 1'b0;
    else if (ie_set) ie_d = 1'b1;
  end

`ifdef CDP1802_DMA_IN_EN
  localparam logic [PHASE_W-1:0] TPA_P = PHASE_W'(TPA_PHASE);

  logic       dmaInReq_q, dmaIn_q, ramWr_q;
  logic [7:0] ramD_q;

  // DMA-in shares S2 with DMA-out; dmaIn_q remembers which kind this cycle is.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dmaInReq_q <= 1'b0;
      dmaIn_q    <= 1'b0;
      ramWr_q    <= 1'b0;
      ramD_q     <= 8'h00;
    end else begin
      if (phase == TPB_P) dmaInReq_q <= ~DMAI;
      if (cycleEnd)       dmaIn_q    <= (state_d == ST_DMA) && dmaInReq_q;
      ramWr_q <= (state_q == ST_DMA) && dmaIn_q &&
                 (phaseNext >= XFER_FIRST) && (phaseNext <= XFER_LAST);
      if ((state_q == ST_DMA) && dmaIn_q && (phase == TPA_P)) ramD_q <= dma_in_data;
    end
  end

  assign dmaInSeen  = dmaInReq_q;
  assign dmaInCycle = dmaIn_q;
  assign ram_wr     = ramWr_q;
  assign ram_d      = ramD_q;
`else
  assign dmaInSeen  = 1'b0;
  assign dmaInCycle = 1'b0;
`endif

  assign r0_out     = r0_q;
  assign ram_a      = r0_q;
  assign ram_rd     = ramRd_q;
  assign dma_data   = dmaData_q;
  assign SC         = state_q;
  assign ie         = ie_q;
  assign int_ack    = intAck_q;
  assign core_stall = stalled;

endmodule

// File: tb/tb_cdp1802_dma_responder.sv
// Self-checking bench for cdp1802_dma_responder: a cycle-rule reference model
// checked every clock, directed scenarios with literal expectations, then random traffic.
module tb_cdp1802_dma_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        DMAO = 1'b1, INT = 1'b1;
  logic        ie_set = 1'b0, ie_clr = 1'b0, r0_load = 1'b0;
  logic [15:0] r0_in = 16'h0000;
  logic [15:0] r0_out, ram_a;
  logic        ram_rd, TPA, TPB, ie, int_ack, core_stall;
  logic [7:0]  ram_q, dma_data;
  logic [1:0]  SC;

  logic [7:0]  ram [0:65535];
  assign ram_q = ram[ram_a];

  int checks = 0;
  int failures = 0;

  cdp1802_dma_responder dut (
    .clock(clock), .reset(reset), .DMAO(DMAO), .INT(INT),
    .ie_set(ie_set), .ie_clr(ie_clr), .r0_load(r0_load), .r0_in(r0_in),
    .r0_out(r0_out), .ram_rd(ram_rd), .ram_a(ram_a), .ram_q(ram_q),
    .dma_data(dma_data), .TPA(TPA), .TPB(TPB), .SC(SC), .ie(ie),
    .int_ack(int_ack), .core_stall(core_stall)
  );

  always #5 clock = ~clock;

  // Reference model: one machine cycle is 8 clocks; requests seen at phase 6
  // decide the next cycle, R0 advances at the end of every DMA cycle.
  int unsigned cnt = 0;
  int          mSc = 1;
  logic [15:0] mR0 = 16'h0000;
  logic        mIe = 1'b1;
  logic [7:0]  mDmaData = 8'h00;
  bit          mDmaSeen = 1'b0, mIntSeen = 1'b0;

  initial forever begin
    int ph, nextSc;
    @(posedge clock or negedge reset);
    if (!reset) begin
      cnt = 0; mSc = 1; mR0 = 16'h0000; mIe = 1'b1; mDmaData = 8'h00;
      mDmaSeen = 1'b0; mIntSeen = 1'b0;
    end else begin
      ph = int'(cnt % 8);
      nextSc = mSc;
      if (ph == 6) begin
        mDmaSeen = !DMAO;
        mIntSeen = !INT && mIe;
      end
      if (ph == 5 && mSc == 2) mDmaData = ram[mR0];
      if (ph == 7) begin
        if (mSc == 0)      nextSc = 1;
        else if (mSc == 3) nextSc = 0;
        else               nextSc = mDmaSeen ? 2 : (mIntSeen ? 3 : 0);
      end
      if (ph == 7 && mSc == 2)      mR0 = mR0 + 16'd1;
      else if (r0_load && mSc < 2)  mR0 = r0_in;
      if (ph == 7 && nextSc == 3)   mIe = 1'b0;
      else if (ie_clr)              mIe = 1'b0;
      else if (ie_set)              mIe = 1'b1;
      mSc = nextSc;
      cnt++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string what);
    checks++;
    failures++;
    $display("[TB] FAIL timeout_%s actual=expired expected=reached at %0t", what, $time);
  endtask

  // Compare process: every falling edge, all outputs against the model.
  bit      captureOn = 1'b0;
  logic [7:0] dmaQ[$];
  int      stallCnt = 0;
  int      ackCount = 0;

  initial forever begin
    int ph;
    @(negedge clock);
    ph = int'(cnt % 8);
    checkOutput("SC", SC, mSc);
    checkOutput("TPA", TPA, ph == 1);
    checkOutput("TPB", TPB, ph == 6);
    checkOutput("ram_rd", ram_rd, (mSc == 2) && ph >= 2 && ph <= 5);
    checkOutput("int_ack", int_ack, (mSc == 3) && ph == 0);
    checkOutput("core_stall", core_stall, mSc >= 2);
    checkOutput("r0_out", r0_out, mR0);
    checkOutput("ram_a", ram_a, mR0);
    checkOutput("ie", ie, mIe);
    checkOutput("dma_data", dma_data, mDmaData);
    if (int_ack) ackCount++;
    if (captureOn && SC == 2 && TPB) dmaQ.push_back(dma_data);
    if (captureOn && SC == 2) stallCnt += int'(core_stall);
  end

  // Wait until the model reaches machine state sc (or any if -1) at phase ph.
  task automatic waitCycle(input int sc, input int ph, input string what);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!((sc < 0 || mSc == sc) && int'(cnt % 8) == ph) && n < 200);
    if (n >= 200) timeoutFail(what);
  endtask

  task automatic loadR0(input logic [15:0] value);
    waitCycle(0, 0, "load_s0");
    r0_in = value;
    r0_load = 1'b1;
    @(negedge clock);
    r0_load = 1'b0;
  endtask

  task automatic applyStimulus(input int clocks);
    for (int i = 0; i < clocks; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 9) == 0) DMAO = ~DMAO;
      if ($urandom_range(0, 11) == 0) INT = ~INT;
      ie_set  = ($urandom_range(0, 15) == 0);
      ie_clr  = ($urandom_range(0, 15) == 0);
      r0_load = ($urandom_range(0, 11) == 0);
      r0_in   = 16'($urandom);
    end
    @(negedge clock);
    ie_set = 1'b0; ie_clr = 1'b0; r0_load = 1'b0; DMAO = 1'b1; INT = 1'b1;
  endtask

  initial begin
    int ack0;
    for (int a = 0; a < 65536; a++) ram[a] = 8'($urandom);
    for (int i = 0; i < 8; i++) ram[16'h0300 + i] = 8'(8'h11 * (i + 1));
    ram[16'hFFFF] = 8'h5A;

    // Reset and idle S1/S0 alternation.
    repeat (3) @(negedge clock);
    reset = 1'b1;
    checkOutput("first_cycle_exec", SC, 1);
    waitCycle(-1, 0, "second_cycle");
    checkOutput("second_cycle_fetch", SC, 0);
    waitCycle(-1, 1, "tpa_phase");
    checkOutput("tpa_at_phase1", TPA, 1);
    waitCycle(-1, 6, "tpb_phase");
    checkOutput("tpb_at_phase6", TPB, 1);
    checkOutput("ie_after_reset", ie, 1);
    waitCycle(-1, 0, "third_cycle");
    checkOutput("third_cycle_exec", SC, 1);

    // Eight back-to-back DMA-out cycles from 0x0300.
    loadR0(16'h0300);
    waitCycle(1, 0, "dma_start");
    DMAO = 1'b0;
    captureOn = 1'b1;
    for (int k = 0; k < 8; k++) waitCycle(2, 0, "dma_burst");
    DMAO = 1'b1;
    waitCycle(0, 0, "dma_done");
    captureOn = 1'b0;
    checkOutput("dma_count", dmaQ.size(), 8);
    for (int i = 0; i < dmaQ.size() && i < 8; i++)
      checkOutput("dma_byte", dmaQ[i], 8'h11 * (i + 1));
    checkOutput("r0_after_burst", r0_out, 16'h0308);
    checkOutput("stall_clocks", stallCnt, 64);

    // Interrupt accepted once, then masked until ie_set.
    waitCycle(1, 0, "int_s1");
    INT = 1'b0;
    ack0 = ackCount;
    waitCycle(3, 0, "int_enter");
    checkOutput("int_ack_pulse", int_ack, 1);
    @(negedge clock);
    checkOutput("int_ack_one_clock", int_ack, 0);
    checkOutput("ie_cleared", ie, 0);
    repeat (40) @(negedge clock);
    checkOutput("int_masked", ackCount - ack0, 1);
    ie_set = 1'b1;
    @(negedge clock);
    ie_set = 1'b0;
    waitCycle(3, 0, "int_reenter");
    INT = 1'b1;
    @(negedge clock);
    checkOutput("int_after_ie_set", ackCount - ack0, 2);

    // DMA pre-empts a pending interrupt; S3 follows the last S2.
    ie_set = 1'b1;
    @(negedge clock);
    ie_set = 1'b0;
    waitCycle(1, 0, "mix_s1");
    DMAO = 1'b0;
    INT = 1'b0;
    for (int k = 0; k < 3; k++) waitCycle(2, 0, "mix_dma");
    DMAO = 1'b1;
    repeat (8) @(negedge clock);
    checkOutput("s3_after_dma", SC, 3);
    INT = 1'b1;

    // R0 wrap from all-ones.
    loadR0(16'hFFFF);
    waitCycle(1, 0, "wrap_s1");
    DMAO = 1'b0;
    waitCycle(2, 0, "wrap_s2");
    DMAO = 1'b1;
    checkOutput("ram_a_ffff", ram_a, 16'hFFFF);
    waitCycle(-1, 6, "wrap_tpb");
    checkOutput("dma_data_ffff", dma_data, 8'h5A);
    waitCycle(0, 0, "wrap_done");
    checkOutput("r0_wrapped", r0_out, 16'h0000);

    // Reset in the middle of a DMA cycle.
    loadR0(16'h1234);
    waitCycle(1, 0, "rst_s1");
    DMAO = 1'b0;
    waitCycle(2, 3, "rst_s2");
    checkOutput("ram_rd_before_reset", ram_rd, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("ram_rd_on_reset", ram_rd, 0);
    checkOutput("r0_on_reset", r0_out, 16'h0000);
    DMAO = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    checkOutput("sc_after_reset", SC, 1);
    checkOutput("r0_after_reset", r0_out, 16'h0000);

    $display("[TB] random traffic");
    applyStimulus(3000);
    repeat (16) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cdp1802_dma_responder.md
Name: cdp1802_dma_responder

Overview:
- CPU-side responder to the CDP1861 video controller.
- Generates the machine-cycle timing (TPA, TPB, SC) that the 1861 counts.
- Arbitrates each machine cycle between the core (S0/S1), DMA-out (S2) and interrupt (S3).
- Services 1861 DMAO requests: reads RAM at R0 and presents the byte on dma_data in SC=2 at TPB, then post-increments R0. Services INT with an S3 acknowledge cycle.

Parameters:
- CLKS_PER_CYCLE, 8, clocks per machine cycle; phase counts 0..CLKS_PER_CYCLE-1.
- TPA_PHASE, 1, phase on which TPA is high.
- TPB_PHASE, 6, phase on which TPB is high; must be greater than TPA_PHASE + 2.
- ADDR_W, 16, width of R0 and ram_a.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- DMAO  in  1  DMA-out request from the 1861, active low.
- INT  in  1  interrupt request from the 1861, active low.
- ie_set  in  1  core pulse: set IE (RET).
- ie_clr  in  1  core pulse: clear IE (DIS).
- r0_load  in  1  core loads R0 from r0_in.
- r0_in  in  ADDR_W  new R0 value.
- r0_out  out  ADDR_W  current R0.
- ram_rd  out  1  RAM read strobe.
- ram_a  out  ADDR_W  RAM address (R0).
- ram_q  in  8  RAM read data.
- dma_data  out  8  DMA byte to the 1861 DataIn.
- TPA  out  1  timing pulse A.
- TPB  out  1  timing pulse B.
- SC  out  2  state code: 0 fetch, 1 execute, 2 DMA, 3 interrupt.
- ie  out  1  interrupt enable.
- int_ack  out  1  one-clock pulse on entry to S3.
- core_stall  out  1  high while SC is 2 or 3; the core holds its state.

Behaviour:
- Reset (asynchronous, while reset=0):
  - phase=0, SC=1 (initialise cycle), R0=0, ie=1.
  - TPA=0, TPB=0, ram_rd=0, ram_a=0, dma_data=0, int_ack=0, core_stall=0.
- First cycle after reset release runs as S1.
- Phase counter:
  - Increments every clock; wraps from CLKS_PER_CYCLE-1 to 0.
  - TPA and TPB are registered, high exactly one clock per cycle at their phases.
  - TPA and TPB are generated in every state, including S2 and S3.
- Next-state decision (registered at phase CLKS_PER_CYCLE-1; SC changes on the clock into phase 0):
  - From S0: always S1.
  - From S1 or S2, in priority order:
    - DMAO==0 sampled at TPB_PHASE -> S2.
    - Else INT==0 sampled at TPB_PHASE and ie==1 -> S3.
    - Else S0.
  - From S3: always S0.
  - Consequences: back-to-back S2 cycles continue while DMAO stays low; DMA pre-empts a pending interrupt; an interrupt is never taken directly after S0.
- S2 (DMA-out):
  - ram_a = R0.
  - ram_rd high for phases 2..TPB_PHASE-1.
  - dma_data captures ram_q at phase TPB_PHASE-1 and holds until the next S2 capture, so it is stable during TPB with SC=2.
  - R0 increments by 1 at the last phase, modulo 2^ADDR_W (all-ones wraps to 0).
- S3 (interrupt):
  - int_ack pulses at phase 0.
  - ie clears at phase 0.
  - No RAM access.
- core_stall equals (SC==2 or SC==3), combinational from the SC register.
- r0_load:
  - Honoured only when SC is 0 or 1.
  - Ignored in S2 and S3, where the core is stalled.
  - If r0_load coincides with the S1-to-S2 boundary clock, the load wins; the S2 cycle uses the loaded value.
- ie priority: ie_clr > ie_set > hold. S3 entry clears ie regardless of ie_set.
- DMAO or INT pulses that do not span TPB_PHASE are not seen.
- Reset asserted mid-S2: cycle aborts, ram_rd drops immediately, R0 returns to 0, no increment.

Optional Feature:
- Macro: CDP1802_DMA_IN_EN.
- Defined:
  - Adds ports DMAI (in, 1, active low), dma_in_data (in, 8) and ram_wr (out, 1), plus ram_d (out, 8).
  - DMAI takes priority over DMAO and INT and also produces SC=2.
  - In a DMA-in cycle, ram_wr is high for phases 2..TPB_PHASE-1 with ram_d = dma_in_data sampled at TPA_PHASE, and ram_rd stays 0.
  - R0 increments as for DMA-out.
- Undefined: none of these ports exist; behaviour is as above.

Decomposition:
- Package cdp1802_pkg:
  - SC encoding constants SC_FETCH=0, SC_EXEC=1, SC_DMA=2, SC_INT=3.
  - Default phase constants.
  - Machine-state enum typedef.
- Sub-module cdp1802_cycle_timer: phase counter, TPA/TPB generation, end-of-cycle strobe. Parameterised by CLKS_PER_CYCLE, TPA_PHASE, TPB_PHASE.

Test Plan:
- Reset release, DMAO=INT=1:
  - SC sequence 1,0,1,0,…
  - TPA at phase 1 and TPB at phase 6 of every 8-clock cycle.
  - ie=1, R0=0.
- Load R0=0x0300; ram[0x300..0x307]=0x11..0x88; hold DMAO=0 for exactly 8 S2 cycles:
  - Eight consecutive SC=2 cycles.
  - dma_data=0x11..0x88 at each TPB.
  - R0 ends at 0x0308.
  - core_stall high throughout.
- INT=0 with ie=1 during S1:
  - Next cycle SC=3.
  - int_ack is a one-clock pulse.
  - ie=0 afterwards.
  - A following INT=0 is ignored until ie_set.
- DMAO=0 and INT=0 together, ie=1:
  - S2 cycles are taken first; S3 follows the last S2 after DMAO goes high.
- R0=0xFFFF, one DMA cycle:
  - ram_a=0xFFFF.
  - R0 wraps to 0x0000.
- Reset pulsed low at phase 3 of an S2 cycle:
  - ram_rd=0 immediately.
  - R0=0, SC=1 after release.
